serial_adder_ctrl: RTL



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/bit_full_adder.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/bit_full_adder.sv
// One-bit full adder cell: two half-adder stages whose carries are ORed.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell sequenced LSB-first.
// Optional carry-out port enabled by defining SERIAL_ADDER_CARRY_OUT_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy
`ifdef SERIAL_ADDER_CARRY_OUT_EN
  ,
  output logic             out_carry
`endif
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ss;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] ss_next;

  bit_full_adder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // The result register sees this cycle's sum bit as well as the earlier ones.
  assign ss_next = {fa_s, ss[WIDTH-1:1]};

  // NOTE: every flop here uses <= so all of them sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_sum   <= '0;
      // NOTE: datapath registers are reset too, so an aborted run leaves no stale bits.
      sa        <= '0;
      sb        <= '0;
      ss        <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ADDER_CARRY_OUT_EN
      out_carry <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa       <= in_a;
            sb       <= in_b;
            carry    <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          ss    <= ss_next;
          carry <= fa_cout;
          if (cnt == CNT_LAST) begin
            // Counter holds on the last bit so it never wraps at power-of-two widths.
            out_sum   <= ss_next;
`ifdef SERIAL_ADDER_CARRY_OUT_EN
            out_carry <= fa_cout;
`endif
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
